// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and defaults for the multi-port register file.
//   rf_state_t : clear-sweep FSM states (IDLE, SWEEP, DONE)
//   RF_XLEN    : default register width
//   RF_NREGS   : default register count
package reg_file_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } rf_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bus between decode/writeback (master) and reg_file_mp (slave).
//   rs        : packed read indices, port k at [k*AW +: AW]
//   read_data : packed read data, port k at [k*XLEN +: XLEN]
//   wr_valid / wr_ready / rd / wr_data : write port
//   clr_req / busy / clr_done          : clear sweep control and status
//   dbg_state : current clear-FSM state, for observation only
//
// Write handshake: a write transfers on a rising edge where wr_valid and
// wr_ready are both 1. rd and wr_data must be stable while wr_valid is
// high; wr_ready does not depend on wr_valid, and the master may hold
// wr_valid across cycles until the transfer happens.
interface reg_file_mp_if #(
  parameter int XLEN  = reg_file_pkg::RF_XLEN,
  parameter int NREGS = reg_file_pkg::RF_NREGS,
  parameter int NRD   = 2
) ();
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]       rs;
  logic [NRD*XLEN-1:0]     read_data;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [AW-1:0]           rd;
  logic [XLEN-1:0]         wr_data;
  logic                    clr_req;
  logic                    busy;
  logic                    clr_done;
  reg_file_pkg::rf_state_t dbg_state;

  modport master (
    output rs, wr_valid, rd, wr_data, clr_req,
    input  read_data, wr_ready, busy, clr_done, dbg_state
  );

  modport slave (
    input  rs, wr_valid, rd, wr_data, clr_req,
    output read_data, wr_ready, busy, clr_done, dbg_state
  );

endinterface

// File: rtl/reg_file_clr_fsm.sv
// reg_file_clr_fsm: clear-sweep controller for reg_file_mp.
// Ports:
//   clk, reset (sync, active-low)
//   clr_req  : start a sweep (honoured only in IDLE)
//   busy     : high in SWEEP
//   clr_done : one-cycle pulse in DONE
//   wr_ready : high only in IDLE
//   clr_en / clr_idx : zero storage[clr_idx] at the next edge
//   state    : current FSM state
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          wr_ready,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx,
  output rf_state_t     state
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy     = 1'b0;
    clr_done = 1'b0;
    wr_ready = 1'b0;
    clr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        // Register 0 is hardwired, so the sweep starts at 1.
        if (clr_req) begin
          state_d = SWEEP;
          ptr_d   = AW'(1);
        end
      end
      SWEEP: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == AW'(NREGS - 1)) state_d = DONE;
      end
      DONE: begin
        clr_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_idx = ptr_q;
  assign state   = state_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with NRD combinational read
// ports, one valid/ready write port and a one-register-per-cycle clear sweep.
// Register 0 is hardwired to zero.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : reg_file_mp_if.slave (read indices/data, write port, sweep control)
// Build option:
//   REG_FILE_BYPASS_EN : forward an accepted write to matching read ports
//                        in the same cycle.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_mp_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic                fsm_busy, fsm_done, fsm_ready, clr_en;
  logic [AW-1:0]       clr_idx;
  rf_state_t           fsm_state;
  logic                wr_fire;
  logic [NRD*XLEN-1:0] rdata;

  reg_file_clr_fsm #(.NREGS(NREGS)) u_clr_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (bus.clr_req),
    .busy     (fsm_busy),
    .clr_done (fsm_done),
    .wr_ready (fsm_ready),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx),
    .state    (fsm_state)
  );

  assign wr_fire = bus.wr_valid && fsm_ready;

  // clr_en and wr_fire are mutually exclusive: writes are only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (clr_en) begin
      regs_q[clr_idx] <= '0;
    end else if (wr_fire && (bus.rd != '0)) begin
      regs_q[bus.rd] <= bus.wr_data;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] val;
      idx = bus.rs[k*AW +: AW];
      val = (idx == '0) ? '0 : regs_q[idx];
`ifdef REG_FILE_BYPASS_EN
      if (wr_fire && (fsm_state == IDLE) && (bus.rd != '0) && (idx == bus.rd))
        val = bus.wr_data;
`endif
      rdata[k*XLEN +: XLEN] = val;
    end
  end

  assign bus.read_data = rdata;
  assign bus.wr_ready  = fsm_ready;
  assign bus.busy      = fsm_busy;
  assign bus.clr_done  = fsm_done;
  assign bus.dbg_state = fsm_state;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [XLEN-1:0] model [NREGS];
  logic [XLEN-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [XLEN-1:0] model_read(input int idx);
    return (idx == 0) ? '0 : model[idx];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rs(input int k, input int idx);
    bus.rs[k*AW +: AW] = AW'(idx);
  endtask

  function automatic logic [XLEN-1:0] port(input int k);
    return bus.read_data[k*XLEN +: XLEN];
  endfunction

  task automatic write_reg(input int idx, input logic [XLEN-1:0] val);
    bus.wr_valid = 1'b1;
    bus.rd       = AW'(idx);
    bus.wr_data  = val;
    tick();
    bus.wr_valid = 1'b0;
    if (idx != 0) model[idx] = val;
  endtask

  task automatic check_all_regs(input string name);
    for (int r = 0; r < NREGS; r++) begin
      for (int k = 0; k < NRD; k++) set_rs(k, r);
      #1;
      for (int k = 0; k < NRD; k++)
        check($sformatf("%s r%0d p%0d", name, r, k), port(k), model_read(r));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int r = 0; r < NREGS; r++) model[r] = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int              rd;
    logic [XLEN-1:0] data;
    int              rs0;
    int              rs1;
    logic [XLEN-1:0] exp0;
    logic [XLEN-1:0] exp1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cyc_busy, cyc_done, done_pulses;
    logic [XLEN-1:0] old7;

    bus.rs = '0; bus.wr_valid = 1'b0; bus.rd = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state.
    #1;
    check("reset wr_ready", 32'(bus.wr_ready), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset clr_done", 32'(bus.clr_done), 32'd0);
    check("reset state", 32'(bus.dbg_state), 32'(IDLE));
    check_all_regs("reset");

    // Write then read on the next cycle; expected values are constants.
    tbl[0] = '{15, 32'h12345678, 15, 0,  32'h12345678, 32'h0};
    tbl[1] = '{20, 32'habcdef12, 15, 20, 32'h12345678, 32'habcdef12};
    tbl[2] = '{0,  32'hdeadbeef, 0,  0,  32'h0,        32'h0};
    tbl[3] = '{31, 32'h00000001, 31, 31, 32'h00000001, 32'h00000001};
    tbl[4] = '{1,  32'hffffffff, 1,  20, 32'hffffffff, 32'habcdef12};
    tbl[5] = '{20, 32'h55aa55aa, 20, 15, 32'h55aa55aa, 32'h12345678};
    foreach (tbl[i]) begin
      write_reg(tbl[i].rd, tbl[i].data);
      set_rs(0, tbl[i].rs0);
      set_rs(1, tbl[i].rs1);
      #1;
      check($sformatf("tbl%0d p0", i), port(0), tbl[i].exp0);
      check($sformatf("tbl%0d p1", i), port(1), tbl[i].exp1);
    end

    // Same-cycle read of a register being written.
    old7 = model[7];
    set_rs(0, 7);
    set_rs(1, 7);
    bus.wr_valid = 1'b1; bus.rd = AW'(7); bus.wr_data = 32'hcafe0001;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("bypass same cycle", port(0), 32'hcafe0001);
`else
    check("no-bypass same cycle", port(0), old7);
`endif
    tick();
    bus.wr_valid = 1'b0;
    model[7] = 32'hcafe0001;
    #1;
    check("write next cycle", port(0), 32'hcafe0001);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int wrd, rsv;
      logic wv;
      logic [XLEN-1:0] wd;
      wv  = ($urandom_range(0, 3) != 0);
      wrd = $urandom_range(0, NREGS - 1);
      wd  = $urandom;
      bus.wr_valid = wv; bus.rd = AW'(wrd); bus.wr_data = wd;
      for (int k = 0; k < NRD; k++) begin
        logic [XLEN-1:0] e;
        rsv = ($urandom_range(0, 3) == 0) ? wrd : $urandom_range(0, NREGS - 1);
        set_rs(k, rsv);
        e = model_read(rsv);
`ifdef REG_FILE_BYPASS_EN
        if (wv && wrd != 0 && rsv == wrd) e = wd;
`endif
        exp_q.push_back(e);
      end
      #1;
      for (int k = 0; k < NRD; k++)
        check($sformatf("rand%0d p%0d", n, k), port(k), exp_q.pop_front());
      tick();
      if (wv && wrd != 0) model[wrd] = wd;
    end
    bus.wr_valid = 1'b0;

    // Full sweep with a same-cycle write, a held write and ignored clr_req pulses.
    for (int r = 1; r < NREGS; r++) write_reg(r, 32'h01010101 * r + 32'h100);
    bus.clr_req = 1'b1;
    bus.wr_valid = 1'b1; bus.rd = AW'(5); bus.wr_data = 32'h0badf00d;
    tick();                          // edge E0: write to r5 commits, sweep starts
    bus.wr_data = 32'h600dcafe;      // held write, must wait for wr_ready
    cyc_busy = 0; cyc_done = 0;
    for (int c = 1; c <= 33; c++) begin
      bus.clr_req = (c == 5 || c == 32);
      #1;
      check($sformatf("sweep c%0d busy", c), 32'(bus.busy), 32'(c <= NREGS - 1));
      check($sformatf("sweep c%0d done", c), 32'(bus.clr_done), 32'(c == NREGS));
      check($sformatf("sweep c%0d ready", c), 32'(bus.wr_ready), 32'(c >= NREGS + 1));
      if (bus.busy) cyc_busy++;
      if (bus.clr_done) cyc_done = c;
      if (c == 10) begin
        set_rs(0, 5);
        set_rs(1, 20);
        #1;
        check("mid-sweep swept r5", port(0), 32'h0);
        check("mid-sweep old r20", port(1), model[20]);
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.clr_req = 1'b0;
    check("sweep busy cycles", 32'(cyc_busy), 32'd31);
    check("sweep done cycle", 32'(cyc_done), 32'd32);
    for (int r = 0; r < NREGS; r++) model[r] = '0;
    model[5] = 32'h600dcafe;
    check_all_regs("after sweep");

    // Reset in the middle of a sweep.
    for (int r = 1; r < NREGS; r += 3) write_reg(r, 32'hf0f00000 | r);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    #1;
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int r = 0; r < NREGS; r++) model[r] = '0;
    #1;
    check("post-reset busy", 32'(bus.busy), 32'd0);
    check("post-reset ready", 32'(bus.wr_ready), 32'd1);
    check_all_regs("post-reset");
    done_pulses = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.clr_done) done_pulses++;
      tick();
    end
    check("no clr_done after reset", 32'(done_pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
